// File: rtl/display_scan_mux.sv
// Time-multiplexed scan driver for multi-digit 7-segment displays: one shared segment bus,
// one-hot digit enables, a dark lead-in at the start of each digit slot to suppress ghosting.
module display_scan_mux #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned DWELL      = 50000,
    parameter int unsigned BLANK      = 500,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NDIG-1:0]         digit_mask,
    input  logic [6:0]              segments_in [NDIG],
    output logic [6:0]              seg_out,
    output logic [NDIG-1:0]         digit_sel,
    output logic [$clog2(NDIG)-1:0] scan_idx,
    output logic                    frame_tick
);

    localparam int unsigned CW = $clog2(DWELL);
    localparam int unsigned IW = $clog2(NDIG);

    localparam logic [CW-1:0]   CntLast  = CW'(DWELL - 1);
    localparam logic [CW-1:0]   BlankCnt = CW'(BLANK);
    localparam logic [IW-1:0]   IdxLast  = IW'(NDIG - 1);
    localparam logic [6:0]      SegOff   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [NDIG-1:0] DigOff   = ACTIVE_LOW ? {NDIG{1'b1}} : {NDIG{1'b0}};
    localparam logic [NDIG-1:0] DigOne   = {{(NDIG - 1){1'b0}}, 1'b1};

    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic [6:0]      r_seg;
    logic [NDIG-1:0] r_dig;
    logic            r_tick;

    logic [CW-1:0]   w_cnt_d;
    logic [IW-1:0]   w_idx_d;
    logic            w_tick_d;
    logic            w_lit;
    logic [NDIG-1:0] w_onehot;
    logic [6:0]      w_seg_d;
    logic [NDIG-1:0] w_dig_d;

    // A disabled cycle holds the counters, so a wrap coinciding with enable low never ticks.
    always_comb begin
        w_cnt_d  = r_cnt;
        w_idx_d  = r_idx;
        w_tick_d = 1'b0;
        if (enable) begin
            if (r_cnt == CntLast) begin
                w_cnt_d  = '0;
                w_tick_d = (r_idx == IdxLast);
                w_idx_d  = (r_idx == IdxLast) ? '0 : r_idx + 1'b1;
            end else begin
                w_cnt_d = r_cnt + 1'b1;
            end
        end
    end

    // Outputs are decoded from next-state so they line up with the registered cnt/idx.
    always_comb begin
        w_lit    = enable && (w_cnt_d >= BlankCnt) && digit_mask[w_idx_d];
        w_onehot = DigOne << w_idx_d;
        w_seg_d  = SegOff;
        w_dig_d  = DigOff;
        if (w_lit) begin
            w_seg_d = segments_in[w_idx_d];
            w_dig_d = ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_seg  <= SegOff;
            r_dig  <= DigOff;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_d;
            r_idx  <= w_idx_d;
            r_seg  <= w_seg_d;
            r_dig  <= w_dig_d;
            r_tick <= w_tick_d;
        end
    end

    assign seg_out    = r_seg;
    assign digit_sel  = r_dig;
    assign scan_idx   = r_idx;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with NDIG=4, DWELL=8, BLANK=2, active-low outputs.
module tb_display_scan_mux;

    localparam int NDIG  = 4;
    localparam int DWELL = 8;
    localparam int BLANK = 2;
    localparam int FRAME = NDIG * DWELL;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] digit_mask = 4'hF;
    logic [6:0] segments_in [NDIG];
    logic [6:0] seg_out;
    logic [3:0] digit_sel;
    logic [1:0] scan_idx;
    logic       frame_tick;

    int   vectors = 0;
    int   miscompares = 0;
    int   pos = 0;
    logic last_en = 1'b0;

    display_scan_mux #(
        .NDIG       (NDIG),
        .DWELL      (DWELL),
        .BLANK      (BLANK),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .digit_mask  (digit_mask),
        .segments_in (segments_in),
        .seg_out     (seg_out),
        .digit_sel   (digit_sel),
        .scan_idx    (scan_idx),
        .frame_tick  (frame_tick)
    );

    always #5 clock = ~clock;

    // pos counts enabled edges since reset release: cnt = pos % DWELL, idx = pos / DWELL.
    function automatic logic [6:0] exp_seg(int p, logic en);
        int c;
        int i;
        c = p % DWELL;
        i = (p / DWELL) % NDIG;
        if (!en || c < BLANK || !digit_mask[i]) return 7'h7F;
        return segments_in[i];
    endfunction

    function automatic logic [3:0] exp_dig(int p, logic en);
        int c;
        int i;
        logic [3:0] one;
        c = p % DWELL;
        i = (p / DWELL) % NDIG;
        one = 4'b0001;
        if (!en || c < BLANK || !digit_mask[i]) return 4'hF;
        return ~(one << i);
    endfunction

    function automatic logic [1:0] exp_idx(int p);
        return 2'((p / DWELL) % NDIG);
    endfunction

    function automatic logic exp_tick(int p, logic en);
        return en && (p % FRAME == 0);
    endfunction

    task automatic step();
        logic en;
        en = enable;
        @(posedge clock);
        #1;
        last_en = en;
        if (en) pos++;
    endtask

    task automatic advance_to(int target);
        for (int n = 0; n < FRAME && (pos % FRAME) != target; n++) step();
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        enable  = 1'b0;
        #1;
        reset_n = 1'b0;
        #2;
        vectors++;
        if (seg_out !== 7'h7F) begin
            miscompares++;
            $display("FAIL reset_seg got %h want 7f", seg_out);
        end
        vectors++;
        if (digit_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_dig got %h want f", digit_sel);
        end
        vectors++;
        if (scan_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_idx got %0d want 0", scan_idx);
        end
        vectors++;
        if (frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tick got %b want 0", frame_tick);
        end
        enable = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        vectors++;
        if (seg_out !== 7'h7F || digit_sel !== 4'hF || scan_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_hold got seg=%h dig=%h idx=%0d want 7f f 0",
                     seg_out, digit_sel, scan_idx);
        end
    endtask

    task automatic test_normal_scan();
        int last_tick;
        last_tick = 0;
        @(negedge clock);
        reset_n = 1'b1;
        pos = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            step();
            vectors++;
            if (seg_out !== exp_seg(pos, last_en)) begin
                miscompares++;
                $display("FAIL scan_seg pos=%0d got %h want %h", pos, seg_out,
                         exp_seg(pos, last_en));
            end
            vectors++;
            if (digit_sel !== exp_dig(pos, last_en)) begin
                miscompares++;
                $display("FAIL scan_dig pos=%0d got %h want %h", pos, digit_sel,
                         exp_dig(pos, last_en));
            end
            vectors++;
            if (scan_idx !== exp_idx(pos)) begin
                miscompares++;
                $display("FAIL scan_idx pos=%0d got %0d want %0d", pos, scan_idx, exp_idx(pos));
            end
            vectors++;
            if (frame_tick !== exp_tick(pos, last_en)) begin
                miscompares++;
                $display("FAIL scan_tick pos=%0d got %b want %b", pos, frame_tick,
                         exp_tick(pos, last_en));
            end
            if (pos == 2) begin
                vectors++;
                if (digit_sel !== 4'b1110 || seg_out !== 7'h40) begin
                    miscompares++;
                    $display("FAIL slot0_lit got dig=%b seg=%h want 1110 40", digit_sel, seg_out);
                end
            end
            if (pos == 10) begin
                vectors++;
                if (digit_sel !== 4'b1101 || seg_out !== 7'h79) begin
                    miscompares++;
                    $display("FAIL slot1_lit got dig=%b seg=%h want 1101 79", digit_sel, seg_out);
                end
            end
            if (frame_tick === 1'b1) begin
                vectors++;
                if (pos - last_tick != FRAME) begin
                    miscompares++;
                    $display("FAIL tick_period got %0d want %0d", pos - last_tick, FRAME);
                end
                last_tick = pos;
            end
        end
    endtask

    task automatic test_mask();
        advance_to(0);
        digit_mask = 4'b0101;
        for (int k = 0; k < FRAME; k++) begin
            step();
            vectors++;
            if (seg_out !== exp_seg(pos, last_en) || digit_sel !== exp_dig(pos, last_en)) begin
                miscompares++;
                $display("FAIL mask_out pos=%0d got seg=%h dig=%h want %h %h", pos, seg_out,
                         digit_sel, exp_seg(pos, last_en), exp_dig(pos, last_en));
            end
            if (exp_idx(pos) == 2'd1 || exp_idx(pos) == 2'd3) begin
                vectors++;
                if (seg_out !== 7'h7F || digit_sel !== 4'hF) begin
                    miscompares++;
                    $display("FAIL mask_dark pos=%0d got seg=%h dig=%h want 7f f",
                             pos, seg_out, digit_sel);
                end
            end
            vectors++;
            if (frame_tick !== exp_tick(pos, last_en)) begin
                miscompares++;
                $display("FAIL mask_tick pos=%0d got %b want %b", pos, frame_tick,
                         exp_tick(pos, last_en));
            end
        end
        digit_mask = 4'hF;
    endtask

    task automatic test_enable_freeze();
        advance_to(2 * DWELL + 5);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            vectors++;
            if (seg_out !== 7'h7F || digit_sel !== 4'hF || scan_idx !== 2'd2 ||
                frame_tick !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze k=%0d got seg=%h dig=%h idx=%0d tick=%b want 7f f 2 0",
                         k, seg_out, digit_sel, scan_idx, frame_tick);
            end
        end
        enable = 1'b1;
        step();
        vectors++;
        if (digit_sel !== 4'b1011 || seg_out !== 7'h24 || scan_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL resume got dig=%b seg=%h idx=%0d want 1011 24 2",
                     digit_sel, seg_out, scan_idx);
        end
        step();
        vectors++;
        if (digit_sel !== 4'b1011 || scan_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL resume_cnt7 got dig=%b idx=%0d want 1011 2", digit_sel, scan_idx);
        end
        step();
        vectors++;
        if (scan_idx !== 2'd3 || digit_sel !== 4'hF || seg_out !== 7'h7F) begin
            miscompares++;
            $display("FAIL resume_next got idx=%0d dig=%h seg=%h want 3 f 7f",
                     scan_idx, digit_sel, seg_out);
        end
    endtask

    task automatic test_wrap_vs_enable();
        advance_to(FRAME - 1);
        enable = 1'b0;
        step();
        vectors++;
        if (frame_tick !== 1'b0 || scan_idx !== 2'd3) begin
            miscompares++;
            $display("FAIL wrap_hold got tick=%b idx=%0d want 0 3", frame_tick, scan_idx);
        end
        enable = 1'b1;
        step();
        vectors++;
        if (frame_tick !== 1'b1 || scan_idx !== 2'd0 || digit_sel !== 4'hF) begin
            miscompares++;
            $display("FAIL wrap_resume got tick=%b idx=%0d dig=%h want 1 0 f",
                     frame_tick, scan_idx, digit_sel);
        end
    endtask

    task automatic test_live_update();
        advance_to(DWELL + 3);
        vectors++;
        if (seg_out !== 7'h79 || digit_sel !== 4'b1101) begin
            miscompares++;
            $display("FAIL live_before got seg=%h dig=%b want 79 1101", seg_out, digit_sel);
        end
        segments_in[1] = 7'h12;
        step();
        vectors++;
        if (seg_out !== 7'h12 || digit_sel !== 4'b1101) begin
            miscompares++;
            $display("FAIL live_after got seg=%h dig=%b want 12 1101", seg_out, digit_sel);
        end
        segments_in[1] = 7'h79;
    endtask

    task automatic test_mid_reset();
        advance_to(2 * DWELL + 4);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (seg_out !== 7'h7F || digit_sel !== 4'hF || scan_idx !== 2'd0 ||
            frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset got seg=%h dig=%h idx=%0d tick=%b want 7f f 0 0",
                     seg_out, digit_sel, scan_idx, frame_tick);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        pos = 0;
        step();
        vectors++;
        if (seg_out !== 7'h7F || digit_sel !== 4'hF || frame_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_dark got seg=%h dig=%h tick=%b want 7f f 0",
                     seg_out, digit_sel, frame_tick);
        end
        step();
        vectors++;
        if (seg_out !== 7'h40 || digit_sel !== 4'b1110 || scan_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL restart_lit got seg=%h dig=%b idx=%0d want 40 1110 0",
                     seg_out, digit_sel, scan_idx);
        end
        for (int k = 0; k < 2 * DWELL; k++) begin
            step();
            vectors++;
            if (seg_out !== exp_seg(pos, last_en) || digit_sel !== exp_dig(pos, last_en) ||
                scan_idx !== exp_idx(pos)) begin
                miscompares++;
                $display("FAIL restart_scan pos=%0d got seg=%h dig=%h idx=%0d", pos,
                         seg_out, digit_sel, scan_idx);
            end
        end
    endtask

    initial begin
        segments_in[0] = 7'h40;
        segments_in[1] = 7'h79;
        segments_in[2] = 7'h24;
        segments_in[3] = 7'h30;
        test_reset();
        test_normal_scan();
        test_mask();
        test_enable_freeze();
        test_wrap_vs_enable();
        test_live_update();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
